// File: rtl/pokemon_pkg.sv
// Shared overworld definitions: map geometry, step directions, movement FSM states.
package pokemon_pkg;

  localparam int unsigned MAP_W = 320;
  localparam int unsigned MAP_H = 240;

  typedef enum logic [3:0] {
    DIR_UP    = 4'd1,
    DIR_DOWN  = 4'd2,
    DIR_LEFT  = 4'd4,
    DIR_RIGHT = 4'd8
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_PROBE0,
    S_PROBE1,
    S_PROBE2,
    S_DRAIN,
    S_COMMIT
  } mv_state_t;

  // Resolve a multi-bit request to one direction: up > down > left > right.
  function automatic dir_t pick_dir(input logic [3:0] req);
    if (req[0])      return DIR_UP;
    else if (req[1]) return DIR_DOWN;
    else if (req[2]) return DIR_LEFT;
    else             return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Collision RAM read port: address out, data back one cycle later.
interface player_move_ctrl_if #(
  parameter int unsigned ADDR_W = 19
);
  logic [ADDR_W-1:0] col_addr;
  logic [3:0]        col_data;

  modport master (output col_addr, input col_data);
  modport slave  (input col_addr, output col_data);
endinterface

// File: rtl/collision_addr_gen.sv
// Map coordinate to linear collision RAM address: y*MAP_W + x.
module collision_addr_gen
  import pokemon_pkg::*;
#(
  parameter int unsigned ADDR_W = 19
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(MAP_W);

  // Unsigned full-width multiply-add.
  always_comb begin
    addr = ADDR_W'(y) * ROW_PITCH + ADDR_W'(x);
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player step controller: edge check, three leading-edge collision probes, commit or reject.
module player_move_ctrl
  import pokemon_pkg::*;
#(
  parameter int unsigned SPR_W   = 16,
  parameter int unsigned SPR_H   = 16,
  parameter int unsigned STEP    = 1,
  parameter int unsigned START_X = 152,
  parameter int unsigned START_Y = 112,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_tick,
  input  logic [3:0]                dir_req,
  player_move_ctrl_if.master        col,
  output logic [9:0]                pos_x,
  output logic [9:0]                pos_y,
  output logic                      busy,
  output logic                      move_done,
  output logic                      blocked
);

  mv_state_t         state_q, state_d;
  dir_t              dir_q;
  logic [9:0]        pos_x_q, pos_y_q, cx_q, cy_q;
  logic [9:0]        cand_x, cand_y, probe_x, probe_y, along_w, along_h;
  logic              edge_ok, hit_q, reject_q, move_done_q, blocked_q;
  logic              probe_active;
  logic [1:0]        probe_idx;
  logic [ADDR_W-1:0] probe_addr, col_addr_q;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; ticks outside IDLE are simply not looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (frame_tick && dir_req != '0) state_d = S_CALC;
      S_CALC:   state_d = edge_ok ? S_PROBE0 : S_COMMIT;
      S_PROBE0: state_d = S_PROBE1;
      S_PROBE1: state_d = S_PROBE2;
      S_PROBE2: state_d = S_DRAIN;
      S_DRAIN:  state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy flag and which probe point is being addressed.
  always_comb begin
    busy         = (state_q != S_IDLE);
    probe_active = 1'b0;
    probe_idx    = 2'd0;
    unique case (state_q)
      S_PROBE0: begin probe_active = 1'b1; probe_idx = 2'd0; end
      S_PROBE1: begin probe_active = 1'b1; probe_idx = 2'd1; end
      S_PROBE2: begin probe_active = 1'b1; probe_idx = 2'd2; end
      default:  ;
    endcase
    col.col_addr = probe_active ? probe_addr : col_addr_q;
  end

  // Candidate position and map-edge check for the latched direction.
  always_comb begin
    cand_x  = pos_x_q;
    cand_y  = pos_y_q;
    edge_ok = 1'b0;
    unique case (dir_q)
      DIR_UP: begin
        edge_ok = 32'(pos_y_q) >= STEP;
        cand_y  = pos_y_q - 10'(STEP);
      end
      DIR_DOWN: begin
        edge_ok = 32'(pos_y_q) + SPR_H - 1 + STEP <= MAP_H - 1;
        cand_y  = pos_y_q + 10'(STEP);
      end
      DIR_LEFT: begin
        edge_ok = 32'(pos_x_q) >= STEP;
        cand_x  = pos_x_q - 10'(STEP);
      end
      DIR_RIGHT: begin
        edge_ok = 32'(pos_x_q) + SPR_W - 1 + STEP <= MAP_W - 1;
        cand_x  = pos_x_q + 10'(STEP);
      end
      default: ;
    endcase
  end

  // Leading-edge probe point: start, middle, end of the edge facing the move.
  always_comb begin
    unique case (probe_idx)
      2'd1:    begin along_w = 10'(SPR_W / 2); along_h = 10'(SPR_H / 2); end
      2'd2:    begin along_w = 10'(SPR_W - 1); along_h = 10'(SPR_H - 1); end
      default: begin along_w = '0;             along_h = '0;             end
    endcase
    probe_x = cx_q;
    probe_y = cy_q;
    unique case (dir_q)
      DIR_UP:    begin probe_x = cx_q + along_w; end
      DIR_DOWN:  begin probe_x = cx_q + along_w; probe_y = cy_q + 10'(SPR_H - 1); end
      DIR_LEFT:  begin probe_y = cy_q + along_h; end
      DIR_RIGHT: begin probe_x = cx_q + 10'(SPR_W - 1); probe_y = cy_q + along_h; end
      default:   ;
    endcase
  end

  collision_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .x    (probe_x),
    .y    (probe_y),
    .addr (probe_addr)
  );

  // Datapath: latch request, candidate, sticky hit, commit and result pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_q       <= DIR_UP;
      pos_x_q     <= 10'(START_X);
      pos_y_q     <= 10'(START_Y);
      cx_q        <= '0;
      cy_q        <= '0;
      hit_q       <= 1'b0;
      reject_q    <= 1'b0;
      col_addr_q  <= '0;
      move_done_q <= 1'b0;
      blocked_q   <= 1'b0;
    end else begin
      move_done_q <= 1'b0;
      blocked_q   <= 1'b0;
      col_addr_q  <= col.col_addr;
      unique case (state_q)
        S_IDLE: if (frame_tick && dir_req != '0) dir_q <= pick_dir(dir_req);
        S_CALC: begin
          cx_q     <= cand_x;
          cy_q     <= cand_y;
          reject_q <= !edge_ok;
          hit_q    <= 1'b0;
        end
        S_PROBE1, S_PROBE2, S_DRAIN: hit_q <= hit_q | (col.col_data != '0);
        S_COMMIT: begin
          if (!reject_q && !hit_q) begin
            pos_x_q     <= cx_q;
            pos_y_q     <= cy_q;
            move_done_q <= 1'b1;
          end else begin
            blocked_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign move_done = move_done_q;
  assign blocked   = blocked_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl with a behavioural collision RAM.
module tb_player_move_ctrl;

  localparam int unsigned ADDR_W = 19;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] dir_req = 4'd0;
  logic [9:0] pos_x, pos_y;
  logic       busy, move_done, blocked;

  player_move_ctrl_if #(.ADDR_W(ADDR_W)) col_if ();

  player_move_ctrl #(
    .SPR_W(16), .SPR_H(16), .STEP(1), .START_X(152), .START_Y(112), .ADDR_W(ADDR_W)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .dir_req    (dir_req),
    .col        (col_if),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .busy       (busy),
    .move_done  (move_done),
    .blocked    (blocked)
  );

  always #5 Clk = ~Clk;

  bit [3:0] solid [int unsigned];

  function automatic bit [3:0] mem_rd(input int unsigned a);
    return solid.exists(a) ? solid[a] : 4'd0;
  endfunction

  // Collision RAM: registered read, one cycle of latency.
  always @(posedge Clk) col_if.col_data <= mem_rd(int'(col_if.col_addr));

  typedef struct {
    bit          is_move;
    int unsigned lat;
    int unsigned x;
    int unsigned y;
  } exp_t;

  exp_t        sb[$];
  int unsigned mx, my;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    mx = 152;
    my = 112;
  endtask

  // One tick+dir request; abort_at!=0 pulls reset at that cycle instead of finishing.
  task automatic step(input logic [3:0] dir, input bit retick, input int unsigned abort_at);
    int unsigned ax[3], ay[3], offs[3], cx, cy, pulses, busy_end;
    bit ok, hit;
    exp_t e, got;
    logic [ADDR_W-1:0] prev_addr;
    offs = '{0, 8, 15};
    cx = mx; cy = my; ok = 1'b0;
    if (dir[0]) begin
      ok = my >= 1; cy = my - 1;
      for (int i = 0; i < 3; i++) begin ax[i] = cx + offs[i]; ay[i] = cy; end
    end else if (dir[1]) begin
      ok = my + 16 <= 239; cy = my + 1;
      for (int i = 0; i < 3; i++) begin ax[i] = cx + offs[i]; ay[i] = cy + 15; end
    end else if (dir[2]) begin
      ok = mx >= 1; cx = mx - 1;
      for (int i = 0; i < 3; i++) begin ax[i] = cx; ay[i] = cy + offs[i]; end
    end else begin
      ok = mx + 16 <= 319; cx = mx + 1;
      for (int i = 0; i < 3; i++) begin ax[i] = cx + 15; ay[i] = cy + offs[i]; end
    end
    hit = 1'b0;
    if (ok) for (int i = 0; i < 3; i++) hit |= (mem_rd(ay[i] * 320 + ax[i]) != 0);
    e.is_move = ok && !hit;
    e.lat     = ok ? 7 : 3;
    e.x       = e.is_move ? cx : mx;
    e.y       = e.is_move ? cy : my;
    busy_end  = ok ? 6 : 2;
    if (abort_at == 0) begin
      sb.push_back(e);
      mx = e.x;
      my = e.y;
    end
    prev_addr  = col_if.col_addr;
    frame_tick = 1'b1;
    dir_req    = dir;
    pulses     = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge Clk);
      frame_tick = retick && n == 3;
      dir_req    = (retick && n == 3) ? 4'b0001 : 4'($urandom_range(0, 15));
      if (abort_at == n) begin
        frame_tick = 1'b0;
        Reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge Clk);
          if (move_done || blocked) pulses++;
        end
        Reset_n = 1'b1;
        mx = 152;
        my = 112;
        for (int k = 0; k < 4; k++) begin
          @(negedge Clk);
          if (move_done || blocked) pulses++;
        end
        chk("abort_pos_x", 32'(pos_x), 152);
        chk("abort_pos_y", 32'(pos_y), 112);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pulses", pulses, 0);
        return;
      end
      if (n <= busy_end)          chk($sformatf("busy_c%0d", n), 32'(busy), 1);
      else if (n == busy_end + 1) chk($sformatf("busy_c%0d", n), 32'(busy), 0);
      if (ok && n >= 2 && n <= 4)
        chk($sformatf("probe%0d_addr", n - 2), 32'(col_if.col_addr), ay[n-2] * 320 + ax[n-2]);
      if (!ok && n <= 3)
        chk($sformatf("held_addr_c%0d", n), 32'(col_if.col_addr), 32'(prev_addr));
      if (move_done || blocked) begin
        pulses++;
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          got = sb.pop_front();
          chk("latency", n, got.lat);
          chk("move_done", 32'(move_done), 32'(got.is_move));
          chk("blocked", 32'(blocked), 32'(!got.is_move));
          chk("pos_x", 32'(pos_x), got.x);
          chk("pos_y", 32'(pos_y), got.y);
        end
      end
    end
    chk("pulse_count", pulses, 1);
    chk("sb_pending", sb.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    mx = 152;
    my = 112;
    chk("rst_pos_x", 32'(pos_x), 152);
    chk("rst_pos_y", 32'(pos_y), 112);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_move_done", 32'(move_done), 0);
    chk("rst_blocked", 32'(blocked), 0);
    chk("rst_col_addr", 32'(col_if.col_addr), 0);

    // Free step up.
    step(4'b0001, 1'b0, 0);

    // Solid tile at the middle of the top edge.
    do_reset();
    solid[111 * 320 + 160] = 4'h3;
    step(4'b0001, 1'b0, 0);
    solid.delete();

    // Multi-bit request resolves to up; re-tick while busy is dropped.
    step(4'b0101, 1'b1, 0);

    // Reset during PROBE1, then a right step from the start position.
    step(4'b0001, 1'b0, 3);
    step(4'b1000, 1'b0, 0);
    step(4'b0100, 1'b0, 0);

    // Solid tile under the bottom-left corner blocks a down step.
    solid[128 * 320 + 152] = 4'h1;
    step(4'b0010, 1'b0, 0);
    solid.delete();

    // Walk to the left edge and push past it.
    do_reset();
    for (int i = 0; i < 152; i++) step(4'b0100, 1'b0, 0);
    chk("left_edge_x", 32'(pos_x), 0);
    step(4'b0100, 1'b0, 0);

    // Walk to the bottom edge and push past it.
    do_reset();
    for (int i = 0; i < 112; i++) step(4'b0010, 1'b0, 0);
    chk("bottom_edge_y", 32'(pos_y), 224);
    step(4'b0010, 1'b0, 0);
    step(4'b1010, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
